// File: rtl/guess_round_ctrl.sv
// Round controller for a number-guessing game: fetches a secret from a target
// source, runs the per-round countdown, judges guesses and tracks level progress.
module guess_round_ctrl #(
  parameter int ROUND_TIME       = 30,
  parameter int ROUNDS_PER_LEVEL = 3
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       confirmButton,
  input  logic       sec_tick,
  input  logic [9:0] guess,
  input  logic [1:0] max_digit,
  input  logic [2:0] max_wrong,
  output logic       target_req,
  input  logic       target_valid,
  input  logic [9:0] target,
  output logic [2:0] round,
  output logic [2:0] incorrect_guesses,
  output logic [6:0] timer,
  output logic       hit,
  output logic       miss,
  output logic       invalid,
  output logic       level_done,
  output logic       timeout,
  output logic       busy
);

  localparam logic [6:0] ROUND_TIME_W = 7'(ROUND_TIME);
  localparam logic [2:0] ROUNDS_W     = 3'(ROUNDS_PER_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state, state_d;
  logic [2:0] round_d, incorrect_d;
  logic [6:0] timer_d, timer_dec;
  logic [9:0] secret, secret_d;
  logic [9:0] guess_q, guess_d;
  logic [9:0] guess_limit;
  logic [1:0] max_digit_q;
  logic       confirm_prev;
  logic       level_pend, level_pend_d;
  logic       hit_d, miss_d, invalid_d, timeout_d;
  logic       md_changed, confirm_edge;

  assign md_changed   = (max_digit != max_digit_q);
  assign confirm_edge = confirmButton & ~confirm_prev;
  assign timer_dec    = (timer == 7'd0) ? 7'd0 : timer - 7'd1;
  assign busy         = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    case (max_digit)
      2'd1:    guess_limit = 10'd10;
      2'd2:    guess_limit = 10'd100;
      default: guess_limit = 10'd1000;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state;
    round_d      = round;
    incorrect_d  = incorrect_guesses;
    timer_d      = timer;
    secret_d     = secret;
    guess_d      = guess_q;
    level_pend_d = 1'b0;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    invalid_d    = 1'b0;
    timeout_d    = 1'b0;
    target_req   = 1'b0;

    case (state)
      S_IDLE: begin
        if (max_digit != 2'd0) begin
          state_d     = S_LOAD;
          round_d     = 3'd0;
          incorrect_d = 3'd0;
        end
      end

      S_LOAD: begin
        if (md_changed) begin
          round_d     = 3'd0;
          incorrect_d = 3'd0;
          timer_d     = 7'd0;
          state_d     = (max_digit != 2'd0) ? S_LOAD : S_IDLE;
        end else begin
          target_req = 1'b1;
          if (target_valid) begin
            secret_d = target;
            timer_d  = ROUND_TIME_W;
            state_d  = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (md_changed) begin
          round_d     = 3'd0;
          incorrect_d = 3'd0;
          timer_d     = 7'd0;
          state_d     = (max_digit != 2'd0) ? S_LOAD : S_IDLE;
        end else begin
          if (sec_tick) timer_d = timer_dec;
          // A confirm edge wins over expiry so a last-second guess is still judged.
          if (confirm_edge) begin
            guess_d = guess;
            state_d = S_CHECK;
          end else if (sec_tick && timer_dec == 7'd0) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end

      S_CHECK: begin
        if (guess_q >= guess_limit) begin
          invalid_d = 1'b1;
          state_d   = (timer == 7'd0) ? S_DONE : S_PLAY;
        end else if (guess_q == secret) begin
          hit_d   = 1'b1;
          round_d = round + 3'd1;
          if (round + 3'd1 == ROUNDS_W) begin
            level_pend_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          miss_d      = 1'b1;
          incorrect_d = (incorrect_guesses == 3'd7) ? 3'd7 : incorrect_guesses + 3'd1;
          state_d     = (incorrect_d >= max_wrong || timer == 7'd0) ? S_DONE : S_PLAY;
        end
      end

      S_DONE: begin
        if (max_digit == 2'd0) begin
          state_d = S_IDLE;
        end else if (md_changed) begin
          round_d     = 3'd0;
          incorrect_d = 3'd0;
          timer_d     = 7'd0;
          state_d     = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // level_done trails the final hit by one cycle so event pulses never overlap.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state             <= S_IDLE;
      round             <= 3'd0;
      incorrect_guesses <= 3'd0;
      timer             <= 7'd0;
      secret            <= 10'd0;
      guess_q           <= 10'd0;
      max_digit_q       <= 2'd0;
      confirm_prev      <= 1'b1;
      level_pend        <= 1'b0;
      hit               <= 1'b0;
      miss              <= 1'b0;
      invalid           <= 1'b0;
      level_done        <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state             <= state_d;
      round             <= round_d;
      incorrect_guesses <= incorrect_d;
      timer             <= timer_d;
      secret            <= secret_d;
      guess_q           <= guess_d;
      max_digit_q       <= max_digit;
      confirm_prev      <= confirmButton;
      level_pend        <= level_pend_d;
      hit               <= hit_d;
      miss              <= miss_d;
      invalid           <= invalid_d;
      level_done        <= level_pend;
      timeout           <= timeout_d;
    end
  end

endmodule
